fp_wire_alu_bank: RTL and testbench

- Multi-channel host-controlled arithmetic bank on the FrontPanel clock domain.
- Generalises the single registered wire-in adder to N_CH channels of parametric width, with selectable operation and optional saturation.
- Runs sequentially through the channels on one shared adder/subtractor. Each run is started by a trigger-in pulse and signalled complete by a trigger-out pulse.
- Sits between okWireIn (operands, mode), okTriggerIn (start), okWireOut (results, status) and okTriggerOut (done) endpoints.

---
 rtl/fp_wire_alu_bank.sv | 152 +++++++++++++++
 tb/tb_fp_wire_alu_bank.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/fp_wire_alu_bank.sv
// Multi-channel host-controlled arithmetic bank on the FrontPanel clock.
// One shared adder/subtractor walks the channels in turn after each start pulse.
module fp_wire_alu_bank #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned WIDTH    = 32,
  parameter bit          SATURATE = 1'b0
) (
  input  logic                    okClk,
  input  logic                    rst_n,
  input  logic [N_CH*WIDTH-1:0]   a_in,
  input  logic [N_CH*WIDTH-1:0]   b_in,
  input  logic [1:0]              mode,
  input  logic                    start,
  output logic [N_CH*WIDTH-1:0]   result,
  output logic [N_CH-1:0]         ovf,
  output logic                    busy,
  output logic                    done,
  output logic                    start_missed,
  output logic [15:0]             run_count
);

  localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned BUS_W = N_CH * WIDTH;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;
  localparam logic [1:0] M_CLR = 2'b11;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t            r_state;
  logic [IDX_W-1:0]  r_idx;
  logic [BUS_W-1:0]  r_a;
  logic [BUS_W-1:0]  r_b;
  logic [1:0]        r_mode;
  logic [BUS_W-1:0]  r_result;
  logic [N_CH-1:0]   r_ovf;
  logic              r_busy;
  logic              r_done;
  logic              r_missed;
  logic [15:0]       r_run_count;

  logic [WIDTH-1:0]  w_a_k;
  logic [WIDTH-1:0]  w_b_k;
  logic [WIDTH-1:0]  w_cur_r;
  logic              w_cur_ovf;
  logic [WIDTH-1:0]  w_x;
  logic [WIDTH-1:0]  w_y;
  logic              w_sub;
  logic [WIDTH:0]    w_full;
  logic              w_flag;
  logic [WIDTH-1:0]  w_new_r;
  logic              w_new_ovf;

  // Select the snapshot operands and current state of the active channel.
  always_comb begin
    w_a_k     = '0;
    w_b_k     = '0;
    w_cur_r   = '0;
    w_cur_ovf = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_a_k     = r_a[k*WIDTH +: WIDTH];
        w_b_k     = r_b[k*WIDTH +: WIDTH];
        w_cur_r   = r_result[k*WIDTH +: WIDTH];
        w_cur_ovf = r_ovf[k];
      end
    end
  end

  // Shared WIDTH+1 bit adder/subtractor; the top bit is carry or borrow.
  always_comb begin
    w_sub     = (r_mode == M_SUB);
    w_x       = (r_mode == M_ACC) ? w_cur_r : w_a_k;
    w_y       = (r_mode == M_ACC) ? w_a_k   : w_b_k;
    w_full    = w_sub ? ({1'b0, w_x} - {1'b0, w_y}) : ({1'b0, w_x} + {1'b0, w_y});
    w_flag    = w_full[WIDTH];
    w_new_r   = w_full[WIDTH-1:0];
    w_new_ovf = w_flag;
    if (SATURATE && w_flag) begin
      w_new_r = w_sub ? '0 : '1;
    end
    if (r_mode == M_ACC) begin
      w_new_ovf = w_cur_ovf | w_flag;
    end
    if (r_mode == M_CLR) begin
      w_new_r   = '0;
      w_new_ovf = 1'b0;
    end
  end

  always_ff @(posedge okClk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_mode      <= M_ADD;
      r_result    <= '0;
      r_ovf       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_missed    <= 1'b0;
      r_run_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_mode   <= mode;
            r_idx    <= '0;
            r_busy   <= 1'b1;
            r_missed <= 1'b0;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (start) begin
            r_missed <= 1'b1;
          end
          for (int k = 0; k < N_CH; k++) begin
            if (r_idx == IDX_W'(k)) begin
              r_result[k*WIDTH +: WIDTH] <= w_new_r;
              r_ovf[k]                   <= w_new_ovf;
            end
          end
          if (r_idx == IDX_W'(N_CH - 1)) begin
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_run_count <= r_run_count + 16'd1;
            r_state     <= S_IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign result       = r_result;
  assign ovf          = r_ovf;
  assign busy         = r_busy;
  assign done         = r_done;
  assign start_missed = r_missed;
  assign run_count    = r_run_count;

endmodule

// File: tb/tb_fp_wire_alu_bank.sv
// Directed bench for fp_wire_alu_bank: a wrapping and a saturating instance
// share the same stimulus and are checked against hand-computed values.
module tb_fp_wire_alu_bank;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned WIDTH = 32;
  localparam int unsigned BUS_W = N_CH * WIDTH;

  logic              okClk;
  logic              rst_n;
  logic [BUS_W-1:0]  a_in;
  logic [BUS_W-1:0]  b_in;
  logic [1:0]        mode;
  logic              start;

  logic [BUS_W-1:0]  res_w, res_s;
  logic [N_CH-1:0]   ovf_w, ovf_s;
  logic              busy_w, busy_s;
  logic              done_w, done_s;
  logic              miss_w, miss_s;
  logic [15:0]       cnt_w, cnt_s;

  int n_checks = 0;
  int n_errors = 0;
  int cyc;
  int done_seen;

  fp_wire_alu_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .SATURATE(1'b0)) u_wrap (
    .okClk(okClk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .mode(mode),
    .start(start), .result(res_w), .ovf(ovf_w), .busy(busy_w), .done(done_w),
    .start_missed(miss_w), .run_count(cnt_w)
  );

  fp_wire_alu_bank #(.N_CH(N_CH), .WIDTH(WIDTH), .SATURATE(1'b1)) u_sat (
    .okClk(okClk), .rst_n(rst_n), .a_in(a_in), .b_in(b_in), .mode(mode),
    .start(start), .result(res_s), .ovf(ovf_s), .busy(busy_s), .done(done_s),
    .start_missed(miss_s), .run_count(cnt_s)
  );

  initial okClk = 1'b0;
  always #5 okClk = ~okClk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the negedge where done is high, bounded to 20 cycles.
  task automatic wait_done(output int cycles);
    cycles = 0;
    do begin
      @(negedge okClk);
      cycles++;
    end while (!done_w && cycles < 20);
  endtask

  // Issue one start from the current negedge and return at the done negedge.
  task automatic run_op(input logic [BUS_W-1:0] a, input logic [BUS_W-1:0] b,
                        input logic [1:0] m, input string tag);
    int c;
    a_in  = a;
    b_in  = b;
    mode  = m;
    start = 1'b1;
    @(negedge okClk);
    start = 1'b0;
    chk({tag, "_busy"}, 128'({busy_w, busy_s}), 128'(2'b11));
    wait_done(c);
    chk({tag, "_latency"}, 128'(c), 128'(N_CH));
    chk({tag, "_done"}, 128'({done_w, done_s}), 128'(2'b11));
    chk({tag, "_idle"}, 128'({busy_w, busy_s}), 128'(2'b00));
  endtask

  initial begin
    rst_n = 1'b0;
    a_in  = '0;
    b_in  = '0;
    mode  = 2'b00;
    start = 1'b0;

    #3;
    chk("rst_result", res_w | res_s, 128'd0);
    chk("rst_flags", 128'({ovf_w, ovf_s, busy_w, busy_s, done_w, done_s, miss_w, miss_s}), 128'd0);
    chk("rst_count", 128'({cnt_w, cnt_s}), 128'd0);
    @(negedge okClk);
    rst_n = 1'b1;

    // ADD with a carry on channel 2
    run_op({32'd7, 32'hFFFF_FFFF, 32'd2, 32'd1}, {32'd0, 32'd1, 32'd2, 32'd2}, 2'b00, "add");
    chk("add_res_wrap", res_w, {32'd7, 32'h0000_0000, 32'd4, 32'd3});
    chk("add_res_sat", res_s, {32'd7, 32'hFFFF_FFFF, 32'd4, 32'd3});
    chk("add_ovf", 128'({ovf_w, ovf_s}), 128'({4'b0100, 4'b0100}));
    chk("add_count", 128'({cnt_w, cnt_s}), 128'({16'd1, 16'd1}));

    // SUB with a borrow on channel 0
    run_op({32'd0, 32'd0, 32'd0, 32'd5}, {32'd0, 32'd0, 32'd0, 32'd9}, 2'b01, "sub");
    chk("sub_res_wrap", res_w, {32'd0, 32'd0, 32'd0, 32'hFFFF_FFFC});
    chk("sub_res_sat", res_s, 128'd0);
    chk("sub_ovf", 128'({ovf_w, ovf_s}), 128'({4'b0001, 4'b0001}));

    // CLR then three ACC runs of 0x80000000
    run_op('0, '0, 2'b11, "clr");
    chk("clr_res", res_w | res_s, 128'd0);
    chk("clr_ovf", 128'({ovf_w, ovf_s}), 128'd0);
    run_op({96'd0, 32'h8000_0000}, '0, 2'b10, "acc1");
    chk("acc1_res", {res_w, res_s}, {96'd0, 32'h8000_0000, 96'd0, 32'h8000_0000});
    chk("acc1_ovf", 128'({ovf_w, ovf_s}), 128'd0);
    run_op({96'd0, 32'h8000_0000}, '0, 2'b10, "acc2");
    chk("acc2_res", {res_w, res_s}, {96'd0, 32'h0000_0000, 96'd0, 32'hFFFF_FFFF});
    chk("acc2_ovf", 128'({ovf_w, ovf_s}), 128'({4'b0001, 4'b0001}));
    run_op({96'd0, 32'h8000_0000}, '0, 2'b10, "acc3");
    chk("acc3_res", {res_w, res_s}, {96'd0, 32'h8000_0000, 96'd0, 32'hFFFF_FFFF});
    chk("acc3_ovf", 128'({ovf_w, ovf_s}), 128'({4'b0001, 4'b0001}));
    chk("acc3_count", 128'({cnt_w, cnt_s}), 128'({16'd6, 16'd6}));

    // Start and operand change while running
    a_in  = {32'd4, 32'd3, 32'd2, 32'd1};
    b_in  = {32'd10, 32'd10, 32'd10, 32'd10};
    mode  = 2'b00;
    start = 1'b1;
    @(negedge okClk);
    start = 1'b0;
    @(negedge okClk);
    chk("mid_partial", {res_w[63:0], res_s[63:0]}, {32'd0, 32'd11, 32'd0, 32'd11});
    a_in  = '1;
    start = 1'b1;
    @(negedge okClk);
    start = 1'b0;
    chk("mid_missed", 128'({miss_w, miss_s}), 128'(2'b11));
    wait_done(cyc);
    chk("mid_latency", 128'(cyc), 128'd2);
    chk("mid_res", {res_w, res_s}, {32'd14, 32'd13, 32'd12, 32'd11, 32'd14, 32'd13, 32'd12, 32'd11});
    chk("mid_ovf", 128'({ovf_w, ovf_s}), 128'd0);
    chk("mid_count", 128'({cnt_w, cnt_s}), 128'({16'd7, 16'd7}));

    // Start accepted in the done cycle clears start_missed
    mode  = 2'b11;
    start = 1'b1;
    @(negedge okClk);
    start = 1'b0;
    chk("b2b_state", 128'({miss_w, miss_s, busy_w, busy_s, done_w, done_s}), 128'(6'b001100));
    wait_done(cyc);
    chk("b2b_latency", 128'(cyc), 128'(N_CH));
    chk("b2b_res", res_w | res_s, 128'd0);
    chk("b2b_count", 128'({cnt_w, cnt_s}), 128'({16'd8, 16'd8}));

    // Asynchronous reset in the middle of a run
    a_in  = {4{32'd1}};
    b_in  = {4{32'd1}};
    mode  = 2'b00;
    start = 1'b1;
    @(negedge okClk);
    start = 1'b0;
    @(negedge okClk);
    chk("pre_rst_nonzero", 128'(res_w[31:0]), 128'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_result", res_w | res_s, 128'd0);
    chk("arst_flags", 128'({ovf_w, ovf_s, busy_w, busy_s, done_w, done_s, miss_w, miss_s}), 128'd0);
    chk("arst_count", 128'({cnt_w, cnt_s}), 128'd0);
    @(negedge okClk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge okClk);
      if (done_w || done_s) done_seen++;
    end
    chk("arst_no_done", 128'(done_seen), 128'd0);
    chk("arst_count_hold", 128'({cnt_w, cnt_s}), 128'd0);

    run_op({4{32'd1}}, {4{32'd1}}, 2'b00, "post");
    chk("post_res", {res_w, res_s}, {{4{32'd2}}, {4{32'd2}}});
    chk("post_count", 128'({cnt_w, cnt_s}), 128'({16'd1, 16'd1}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
